// File: rtl/serial_operand_serializer_pkg.sv
// Shared types for the operand serializer and its shift slot.
// Holds the two-state FSM encoding and the bit-counter width helper.
package serial_operand_serializer_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } ser_state_t;

   // Counter must be at least one bit wide even when WIDTH == 1.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_shift_slot.sv
// WIDTH-bit load/shift register pair with bit counter and MSB decode.
// Load wins over shift; bit 0 of each register is the current serial bit.
module serial_shift_slot
   import serial_operand_serializer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] ld_a,
   input  logic [WIDTH-1:0] ld_b,
   output logic             bit_a,
   output logic             bit_b,
   output logic             at_last
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [CW-1:0]    cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_a <= '0;
         sh_b <= '0;
         cnt  <= '0;
      end else if (load) begin
         sh_a <= ld_a;
         sh_b <= ld_b;
         cnt  <= '0;
      end else if (shift) begin
         sh_a <= sh_a >> 1;
         sh_b <= sh_b >> 1;
         cnt  <= cnt + CW'(1);
      end
   end

   assign bit_a   = sh_a[0];
   assign bit_b   = sh_b[0];
   assign at_last = (cnt == CNT_LAST);

endmodule

// File: rtl/serial_operand_serializer.sv
// Parallel operand pair to LSB-first bit-serial stream; bit 0 one cycle after handshake.
// One pending slot lets the next word follow with no bubble; up_ready low while it is full.
module serial_operand_serializer
   import serial_operand_serializer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_a,
   input  logic [WIDTH-1:0] up_b,
   output logic             up_ready,
   output logic             vld,
   output logic             a,
   output logic             b,
   output logic             last
);

   ser_state_t       state_q, state_d;
   logic [WIDTH-1:0] pd_a, pd_b;
   logic             pd_valid;
   logic             hs, busy, at_last, bit_a, bit_b;
   logic             load, shift, pd_wr, pd_clr, use_pd;
   logic [WIDTH-1:0] ld_a, ld_b;

   assign up_ready = rst & ~pd_valid;
   assign hs       = up_valid & up_ready;
   assign busy     = (state_q == ST_SHIFT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // A handshake at word-end bypasses the pending slot; pd_valid forces up_ready low,
   // so pending drain and handshake never coincide.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      shift   = 1'b0;
      pd_wr   = 1'b0;
      pd_clr  = 1'b0;
      use_pd  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hs) begin
               load    = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (!at_last) begin
               shift = 1'b1;
               pd_wr = hs;
            end else if (pd_valid) begin
               load   = 1'b1;
               use_pd = 1'b1;
               pd_clr = 1'b1;
            end else if (hs) begin
               load = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign ld_a = use_pd ? pd_a : up_a;
   assign ld_b = use_pd ? pd_b : up_b;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pd_a     <= '0;
         pd_b     <= '0;
         pd_valid <= 1'b0;
      end else if (pd_wr) begin
         pd_a     <= up_a;
         pd_b     <= up_b;
         pd_valid <= 1'b1;
      end else if (pd_clr) begin
         pd_valid <= 1'b0;
      end
   end

   serial_shift_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .shift   (shift),
      .ld_a    (ld_a),
      .ld_b    (ld_b),
      .bit_a   (bit_a),
      .bit_b   (bit_b),
      .at_last (at_last)
   );

   assign vld  = busy;
   assign a    = busy & bit_a;
   assign b    = busy & bit_b;
   assign last = busy & at_last;

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Bench for serial_operand_serializer (WIDTH=8 and WIDTH=1 instances).
// Expected stream comes from a word-schedule model: start = max(handshake+1, previous end+1).
module tb_serial_operand_serializer;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   logic up_valid;
   logic [W-1:0] up_a, up_b;
   logic up_ready, vld, a, b, last;

   logic v1_valid;
   logic [0:0] v1_a, v1_b;
   logic r1_ready, r1_vld, r1_a, r1_b, r1_last;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   serial_operand_serializer #(.WIDTH(W)) dut8 (
      .clk(clk), .rst(rst), .up_valid(up_valid), .up_a(up_a), .up_b(up_b),
      .up_ready(up_ready), .vld(vld), .a(a), .b(b), .last(last)
   );

   serial_operand_serializer #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .up_valid(v1_valid), .up_a(v1_a), .up_b(v1_b),
      .up_ready(r1_ready), .vld(r1_vld), .a(r1_a), .b(r1_b), .last(r1_last)
   );

   // ---------------- reference model ----------------
   typedef struct {
      int hs;
      int start;
      logic [W-1:0] wa;
      logic [W-1:0] wb;
   } word_t;

   word_t wq[$];
   int    last_end = -100;
   logic [4:0] obs, exp_v;   // {up_ready, vld, last, a, b}
   logic  acc;

   function automatic logic [4:0] model_out(input int c, input logic rst_v);
      logic pend, v, l, ba, bb;
      int k;
      pend = 1'b0; v = 1'b0; l = 1'b0; ba = 1'b0; bb = 1'b0;
      if (!rst_v) return 5'b0;
      foreach (wq[i]) begin
         if (wq[i].hs < c && c < wq[i].start) pend = 1'b1;
         if (c >= wq[i].start && c < wq[i].start + W) begin
            k  = c - wq[i].start;
            v  = 1'b1;
            ba = wq[i].wa[k];
            bb = wq[i].wb[k];
            l  = (k == W - 1);
         end
      end
      return {~pend, v, l, ba, bb};
   endfunction

   // One clock: drive inputs after the edge, sample at the falling edge, advance model.
   task automatic advance(input logic v_in, input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                          input logic rst_in);
      word_t w;
      @(posedge clk);
      #1;
      rst      = rst_in;
      up_valid = v_in;
      up_a     = v_in ? a_in : W'($urandom);
      up_b     = v_in ? b_in : W'($urandom);
      @(negedge clk);
      obs   = {up_ready, vld, last, a, b};
      exp_v = model_out(cyc, rst_in);
      acc   = 1'b0;
      if (!rst_in) begin
         wq.delete();
         last_end = -100;
      end else if (v_in && exp_v[4]) begin
         w.hs    = cyc;
         w.start = (cyc + 1 > last_end + 1) ? cyc + 1 : last_end + 1;
         w.wa    = a_in;
         w.wb    = b_in;
         wq.push_back(w);
         last_end = w.start + W - 1;
         acc = 1'b1;
      end
   endtask

   // Reassembles words from the serial outputs.
   logic [W-1:0] cur_a, cur_b;
   int bidx = 0;
   logic [2*W-1:0] rxq[$];

   task automatic collect();
      if (!rst) begin
         bidx = 0;
      end else if (vld) begin
         cur_a[bidx] = a;
         cur_b[bidx] = b;
         bidx++;
         if (last) begin
            rxq.push_back({cur_a, cur_b});
            bidx = 0;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         advance(1'b1, 8'hAA, 8'h55, 1'b0);
         n_chk++;
         if (obs !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs cyc=%0d got=%b exp=00000", cyc, obs);
         end
      end
      advance(1'b0, 8'h00, 8'h00, 1'b1);
      n_chk++;
      if (obs !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_release cyc=%0d got=%b exp=10000", cyc, obs);
      end
   endtask

   task automatic test_single_word();
      int c0, last_rel, n_last;
      c0 = -1; last_rel = -1; n_last = 0;
      rxq.delete(); bidx = 0;
      for (int i = 0; i < 11; i++) begin
         if (i == 0) advance(1'b1, 8'h5A, 8'h3C, 1'b1);
         else        advance(1'b0, 8'h00, 8'h00, 1'b1);
         if (i == 0) c0 = cyc;
         collect();
         if (last) begin n_last++; last_rel = cyc - c0; end
         n_chk++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL single cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
      end
      n_chk++;
      if (n_last != 1 || last_rel != 8) begin
         n_fail++;
         $display("FAIL single_last count=%0d rel=%0d exp count=1 rel=8", n_last, last_rel);
      end
      n_chk++;
      if (rxq.size() != 1 || rxq[0] !== 16'h5A3C) begin
         n_fail++;
         $display("FAIL single_word n=%0d got=%h exp=5a3c", rxq.size(),
                  (rxq.size() > 0) ? rxq[0] : 16'h0);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] wa[4], wb[4];
      int k, c0, n_vld, first_v, last_v;
      int lasts[$];
      wa[0] = 8'h81; wb[0] = 8'h7E; wa[1] = 8'hC3; wb[1] = 8'h11;
      wa[2] = 8'h0F; wb[2] = 8'hF0; wa[3] = 8'h00; wb[3] = 8'h00;
      k = 0; c0 = -1; n_vld = 0; first_v = -1; last_v = -1;
      for (int i = 0; i < 30; i++) begin
         advance(k < 3, wa[k], wb[k], 1'b1);
         if (i == 0) c0 = cyc;
         if (acc) k++;
         if (vld) begin
            n_vld++;
            if (first_v < 0) first_v = cyc - c0;
            last_v = cyc - c0;
         end
         if (last) lasts.push_back(cyc - c0);
         n_chk++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
      end
      n_chk++;
      if (n_vld != 24 || first_v != 1 || last_v != 24) begin
         n_fail++;
         $display("FAIL b2b_vld n=%0d first=%0d last=%0d exp n=24 first=1 last=24",
                  n_vld, first_v, last_v);
      end
      n_chk++;
      if (lasts.size() != 3 || lasts[0] != 8 || lasts[1] != 16 || lasts[2] != 24) begin
         n_fail++;
         $display("FAIL b2b_last n=%0d exp positions 8,16,24", lasts.size());
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] wa[3], wb[3];
      int c0, k;
      int acc_rel[$];
      wa[0] = 8'h12; wb[0] = 8'h34; wa[1] = 8'hA5; wb[1] = 8'h5A; wa[2] = 8'hE7; wb[2] = 8'h18;
      c0 = -1; k = 0;
      rxq.delete(); bidx = 0;
      for (int i = 0; i < 30; i++) begin
         if (i == 0)                 advance(1'b1, wa[0], wb[0], 1'b1);
         else if (i == 2)            advance(1'b1, wa[1], wb[1], 1'b1);
         else if (i >= 3 && k < 3)   advance(1'b1, wa[2], wb[2], 1'b1);
         else                        advance(1'b0, 8'h00, 8'h00, 1'b1);
         if (i == 0) c0 = cyc;
         if (acc) begin k++; acc_rel.push_back(cyc - c0); end
         collect();
         n_chk++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL bp cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
      end
      n_chk++;
      if (acc_rel.size() != 3 || acc_rel[0] != 0 || acc_rel[1] != 2 || acc_rel[2] != 9) begin
         n_fail++;
         $display("FAIL bp_accept n=%0d exp accepts at 0,2,9", acc_rel.size());
      end
      n_chk++;
      if (rxq.size() != 3 || rxq[0] !== {wa[0], wb[0]} || rxq[1] !== {wa[1], wb[1]} ||
          rxq[2] !== {wa[2], wb[2]}) begin
         n_fail++;
         $display("FAIL bp_words got n=%0d exp 3 words 1234,a55a,e718", rxq.size());
      end
   endtask

   task automatic test_reset_mid_word();
      rxq.delete(); bidx = 0;
      advance(1'b1, 8'h96, 8'h69, 1'b1);
      for (int i = 1; i < 4; i++) advance(1'b0, 8'h00, 8'h00, 1'b1);
      advance(1'b0, 8'h00, 8'h00, 1'b0);
      collect();
      n_chk++;
      if (obs !== 5'b0) begin
         n_fail++;
         $display("FAIL midreset_outputs got=%b exp=00000", obs);
      end
      advance(1'b0, 8'h00, 8'h00, 1'b1);
      n_chk++;
      if (obs !== 5'b10000) begin
         n_fail++;
         $display("FAIL midreset_release got=%b exp=10000", obs);
      end
      advance(1'b1, 8'hFF, 8'h01, 1'b1);
      for (int i = 0; i < 10; i++) begin
         advance(1'b0, 8'h00, 8'h00, 1'b1);
         collect();
         n_chk++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL midreset_stream cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
      end
      n_chk++;
      if (rxq.size() != 1 || rxq[0] !== 16'hFF01) begin
         n_fail++;
         $display("FAIL midreset_word n=%0d exp one word ff01", rxq.size());
      end
   endtask

   task automatic test_random();
      int n_acc;
      n_acc = 0;
      for (int i = 0; i < 400; i++) begin
         advance($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), 1'b1);
         if (acc) n_acc++;
         n_chk++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
      end
      for (int i = 0; i < 20; i++) advance(1'b0, 8'h00, 8'h00, 1'b1);
      n_chk++;
      if (n_acc < 20 || vld !== 1'b0) begin
         n_fail++;
         $display("FAIL random_drain accepted=%0d vld=%b exp >=20 and vld=0", n_acc, vld);
      end
   endtask

   task automatic test_adder_e2e();
      logic [W-1:0] xa[2], xb[2], sum, exp_sum;
      logic carry;
      int k, bi, n_sum;
      xa[0] = 8'hFF; xb[0] = 8'h01; xa[1] = 8'h03; xb[1] = 8'h05;
      k = 0; bi = 0; n_sum = 0; carry = 1'b0; sum = '0;
      for (int i = 0; i < 22; i++) begin
         advance(k < 2, xa[k[0]], xb[k[0]], 1'b1);
         if (acc) k++;
         if (vld) begin
            sum[bi] = a ^ b ^ carry;
            carry   = last ? 1'b0 : ((a & b) | (a & carry) | (b & carry));
            bi++;
            if (last) begin
               exp_sum = xa[n_sum[0]] + xb[n_sum[0]];
               n_chk++;
               if (sum !== exp_sum) begin
                  n_fail++;
                  $display("FAIL adder_sum word=%0d got=%h exp=%h", n_sum, sum, exp_sum);
               end
               n_sum++;
               bi = 0;
            end
         end
      end
      n_chk++;
      if (n_sum != 2) begin
         n_fail++;
         $display("FAIL adder_count got=%0d exp=2", n_sum);
      end
   endtask

   task automatic test_width1();
      logic [4:0] exp1[5];
      logic [1:0] w1[3];
      logic [4:0] o1;
      exp1[0] = 5'b10000; exp1[1] = 5'b11111; exp1[2] = 5'b11101;
      exp1[3] = 5'b11110; exp1[4] = 5'b10000;
      w1[0] = 2'b11; w1[1] = 2'b01; w1[2] = 2'b10;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         up_valid = 1'b0;
         v1_valid = (i < 3);
         v1_a     = (i < 3) ? w1[i][1] : 1'b0;
         v1_b     = (i < 3) ? w1[i][0] : 1'b0;
         @(negedge clk);
         o1 = {r1_ready, r1_vld, r1_last, r1_a, r1_b};
         n_chk++;
         if (o1 !== exp1[i]) begin
            n_fail++;
            $display("FAIL width1 step=%0d got=%b exp=%b", i, o1, exp1[i]);
         end
      end
      v1_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0; up_valid = 1'b0; up_a = '0; up_b = '0;
      v1_valid = 1'b0; v1_a = '0; v1_b = '0;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_word();
      test_random();
      test_adder_e2e();
      test_width1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
